// File: rtl/ysyx_23060203_pkg.sv
// ysyx_23060203_pkg: shared decode types, opcode map and register-file defaults
package ysyx_23060203_pkg;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS} fmt_e;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam int NR_REG_DEF = 16;
endpackage

// File: rtl/ysyx_23060203_scoreboard.sv
// ysyx_23060203_scoreboard: per-register count of in-flight writes with busy/full queries
module ysyx_23060203_scoreboard
  import ysyx_23060203_pkg::*;
#(
  parameter int NR_REG = NR_REG_DEF,
  parameter int SB_W   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inc,
  input  logic [$clog2(NR_REG)-1:0] inc_rd,
  input  logic                      dec,
  input  logic [$clog2(NR_REG)-1:0] dec_rd,
  input  logic [$clog2(NR_REG)-1:0] rs1,
  input  logic [$clog2(NR_REG)-1:0] rs2,
  input  logic [$clog2(NR_REG)-1:0] rd,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rd_full
);
  localparam int RW = $clog2(NR_REG);
  logic [SB_W-1:0] cnt [NR_REG];
  // x0 never counts; an issue and a retire on the same register cancel out
  always_ff @(posedge clock)
    for (int i = 0; i < NR_REG; i++)
      cnt[i] <= reset ? '0 : cnt[i] + SB_W'(inc && inc_rd == RW'(i) && i != 0)
                               - SB_W'(dec && dec_rd == RW'(i) && cnt[i] != '0);
  // a retire must match an outstanding write
  always_ff @(posedge clock)
    if (!reset && dec) assert (dec_rd != '0 && cnt[dec_rd] != '0);
  assign rs1_busy = rs1 != '0 && cnt[rs1] != '0;
  assign rs2_busy = rs2 != '0 && cnt[rs2] != '0;
  assign rd_full  = rd != '0 && &cnt[rd];
endmodule

// File: rtl/ysyx_23060203_idu_issue.sv
// ysyx_23060203_idu_issue: RV32I/E decode with scoreboard-gated issue into one registered slot
module ysyx_23060203_idu_issue
  import ysyx_23060203_pkg::*;
#(
  parameter int NR_REG = NR_REG_DEF,
  parameter int SB_W   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_inst,
  input  logic                      wb_valid,
  input  logic [$clog2(NR_REG)-1:0] wb_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_inst,
  output logic [$clog2(NR_REG)-1:0] out_rs1,
  output logic [$clog2(NR_REG)-1:0] out_rs2,
  output logic [$clog2(NR_REG)-1:0] out_rd,
  output logic                      out_rd_wen,
  output logic [31:0]               out_imm,
  output fmt_e                      out_fmt,
  output logic                      out_illegal
);
  localparam int RW = $clog2(NR_REG);
  logic [4:0] op, rs1_f, rs2_f, rd_f;
  logic known, use1, use2, writes, illegal, rd_wen, issue;
  logic rs1_busy, rs2_busy, rd_full;
  logic [RW-1:0] rs1, rs2, rd;
  logic [31:0] imm;
  fmt_e fmt;
  assign op    = in_inst[6:2];
  assign rs1_f = in_inst[19:15];
  assign rs2_f = in_inst[24:20];
  assign rd_f  = in_inst[11:7];
  // format class, register usage and immediate; trapping instructions never claim rd
  always_comb begin
    known = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_BRANCH,
                       OP_STORE, OP_REG, OP_SYSTEM, OP_FENCE};
    fmt = op == OP_LUI || op == OP_AUIPC ? FMT_U :
          op == OP_JAL ? FMT_J :
          op == OP_JALR || op == OP_LOAD || op == OP_IMM || op == OP_FENCE ? FMT_I :
          op == OP_BRANCH ? FMT_B :
          op == OP_STORE ? FMT_S :
          op == OP_SYSTEM ? FMT_SYS : FMT_R;
    use1 = known && ((fmt inside {FMT_I, FMT_S, FMT_B, FMT_R} && op != OP_FENCE) ||
                     (fmt == FMT_SYS && !in_inst[14]));
    use2 = known && fmt inside {FMT_S, FMT_B, FMT_R};
    writes = known && (fmt inside {FMT_U, FMT_J, FMT_R, FMT_SYS} || (fmt == FMT_I && op != OP_FENCE));
    illegal = !known || in_inst[1:0] != 2'b11 || (use1 && int'(rs1_f) >= NR_REG) ||
              (use2 && int'(rs2_f) >= NR_REG) || (writes && int'(rd_f) >= NR_REG);
    rd_wen = writes && rd_f != 5'd0 && !illegal;
    rs1 = use1 ? rs1_f[RW-1:0] : '0;
    rs2 = use2 ? rs2_f[RW-1:0] : '0;
    rd  = writes ? rd_f[RW-1:0] : '0;
    imm = fmt == FMT_U ? {in_inst[31:12], 12'b0} :
          fmt == FMT_J ? {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
          fmt == FMT_B ? {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
          fmt == FMT_S ? {{21{in_inst[31]}}, in_inst[30:25], in_inst[11:7]} :
          fmt == FMT_I || fmt == FMT_SYS ? {{21{in_inst[31]}}, in_inst[30:20]} : 32'd0;
  end
  assign in_ready = !flush && !(rs1_busy || rs2_busy || (rd_wen && rd_full)) && (!out_valid || out_ready);
  assign issue    = in_valid && in_ready;
  ysyx_23060203_scoreboard #(.NR_REG(NR_REG), .SB_W(SB_W)) u_sb (
    .clock(clock), .reset(reset),
    .inc(issue && rd_wen), .inc_rd(rd),
    .dec(wb_valid), .dec_rd(wb_rd),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_full(rd_full)
  );
  // output slot: data moves only on issue, valid drops on drain or flush
  always_ff @(posedge clock)
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= FMT_R;
      out_illegal <= 1'b0;
    end else begin
      out_valid <= !flush && (issue || (out_valid && !out_ready));
      if (issue) begin
        out_pc      <= in_pc;
        out_inst    <= in_inst;
        out_rs1     <= rs1;
        out_rs2     <= rs2;
        out_rd      <= rd;
        out_rd_wen  <= rd_wen;
        out_imm     <= imm;
        out_fmt     <= fmt;
        out_illegal <= illegal;
      end
    end
endmodule

// File: tb/tb_ysyx_23060203_idu_issue.sv
// tb_ysyx_23060203_idu_issue: directed self-checking bench for the decode/issue stage
module tb_ysyx_23060203_idu_issue;
  import ysyx_23060203_pkg::*;
  logic clock = 1'b0, reset, flush, in_valid, in_ready, wb_valid, out_valid, out_ready;
  logic out_rd_wen, out_illegal;
  logic [31:0] in_pc, in_inst, out_pc, out_inst, out_imm;
  logic [3:0] wb_rd, out_rs1, out_rs2, out_rd;
  fmt_e out_fmt;
  int checks = 0, failures = 0;
  ysyx_23060203_idu_issue dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wb(input logic [3:0] r);
    wb_valid = 1'b1;
    wb_rd = r;
    tick();
    wb_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    wb_valid = 1'b0; wb_rd = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    // addi x1,x0,5
    in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0050_0093;
    #1 chk("addi_ready", 32'(in_ready), 32'd1);
    tick();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_pc", out_pc, 32'h8000_0000);
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_fmt", 32'(out_fmt), 32'(FMT_I));
    chk("addi_wen", 32'(out_rd_wen), 32'd1);
    chk("addi_rs1", 32'(out_rs1), 32'd0);
    // add x2,x1,x1 stalls on x1
    in_pc = 32'h8000_0004; in_inst = 32'h0010_8133;
    #1 chk("raw_stall", 32'(in_ready), 32'd0);
    tick();
    chk("raw_drain", 32'(out_valid), 32'd0);
    tick();
    chk("raw_hold", 32'(out_valid), 32'd0);
    wb(4'd1);
    chk("raw_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_rd", 32'(out_rd), 32'd2);
    chk("add_rs1", 32'(out_rs1), 32'd1);
    chk("add_rs2", 32'(out_rs2), 32'd1);
    chk("add_fmt", 32'(out_fmt), 32'(FMT_R));
    chk("add_imm", out_imm, 32'd0);
    wb(4'd2);
    // beq x0,x0,-8
    in_valid = 1'b1; in_pc = 32'h8000_0008; in_inst = 32'hfe00_0ce3;
    tick();
    chk("beq_imm", out_imm, 32'hffff_fff8);
    chk("beq_fmt", 32'(out_fmt), 32'(FMT_B));
    chk("beq_wen", 32'(out_rd_wen), 32'd0);
    // back-pressure holds the slot
    out_ready = 1'b0; in_pc = 32'h8000_000c; in_inst = 32'h0070_0193;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_imm", out_imm, 32'hffff_fff8);
      chk("bp_pc", out_pc, 32'h8000_0008);
    end
    out_ready = 1'b1;
    #1 chk("bp_resume", 32'(in_ready), 32'd1);
    tick();
    chk("bp_rd", 32'(out_rd), 32'd3);
    chk("bp_newimm", out_imm, 32'd7);
    // flush kills held and arriving instructions
    out_ready = 1'b0; flush = 1'b1; in_pc = 32'h8000_0010; in_inst = 32'h0010_0213;
    #1 chk("flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_rd", 32'(out_rd), 32'd3);
    in_inst = 32'h0001_82b3;
    #1 chk("flush_sb_x3", 32'(in_ready), 32'd0);
    in_inst = 32'h0002_0313;
    #1 chk("flush_sb_x4", 32'(in_ready), 32'd1);
    wb(4'd3);
    // illegal encodings and U format
    in_valid = 1'b1; in_inst = 32'h0020_88b3;
    tick();
    chk("x17_illegal", 32'(out_illegal), 32'd1);
    chk("x17_wen", 32'(out_rd_wen), 32'd0);
    in_inst = 32'h0000_0000;
    tick();
    chk("zero_illegal", 32'(out_illegal), 32'd1);
    in_inst = 32'h0050_0090;
    tick();
    chk("len_illegal", 32'(out_illegal), 32'd1);
    in_inst = 32'h1234_53b7;
    tick();
    chk("lui_illegal", 32'(out_illegal), 32'd0);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_fmt", 32'(out_fmt), 32'(FMT_U));
    chk("lui_rd", 32'(out_rd), 32'd7);
    // counter saturation on x5
    in_inst = 32'h0010_0293;
    for (int i = 0; i < 3; i++) begin
      #1 chk("x5_issue", 32'(in_ready), 32'd1);
      tick();
    end
    #1 chk("x5_full", 32'(in_ready), 32'd0);
    tick();
    chk("x5_stall_valid", 32'(out_valid), 32'd0);
    wb(4'd5);
    chk("x5_after_wb", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("x5_fourth", 32'(out_valid), 32'd1);
    // reset mid-operation clears slot and scoreboard
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_pc", out_pc, 32'd0);
    chk("mrst_rd", 32'(out_rd), 32'd0);
    in_inst = 32'h0052_8333;
    #1 chk("mrst_sb", 32'(in_ready), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
